store_buffer: RTL and testbench

- Sits between the EX/MEM pipeline register and the data memory write port; data memory sits directly downstream.
- Accepts stores from the pipeline into a small in-order FIFO and drains them into data memory on cycles when no load owns the port.
- Flags loads that hit a buffered store address so the hazard unit stalls them.
- Provides a fence handshake that fully drains the buffer.

---
 rtl/store_buffer_if.sv | 33 +++
 rtl/store_buffer.sv | 135 +++++++++++++
 tb/tb_store_buffer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bus: pipeline store/load requests, fence handshake and data memory write port.
// slave is the buffer's view; master is the pipeline/memory side that drives requests.
interface store_buffer_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  st_valid;
  logic                  st_ready;
  logic [DM_ADDRESS-1:0] st_addr;
  logic [DATA_W-1:0]     st_data;
  logic [2:0]            st_funct3;
  logic                  ld_valid;
  logic [DM_ADDRESS-1:0] ld_addr;
  logic                  ld_conflict;
  logic                  fence_req;
  logic                  fence_done;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wd;
  logic [2:0]            mem_funct3;
  logic [3:0]            mem_be;
  logic                  empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, fence_req,
    output st_ready, ld_conflict, fence_done, mem_we, mem_addr, mem_wd, mem_funct3, mem_be, empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, fence_req,
    input  st_ready, ld_conflict, fence_done, mem_we, mem_addr, mem_wd, mem_funct3, mem_be, empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer between EX/MEM and data memory: drains when no load owns the port,
// flags load/store address hazards and supports a draining fence. Optional STORE_BUFFER_STATS_EN.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic clk,
  input  logic rst_n,
  store_buffer_if.slave bus
`ifdef STORE_BUFFER_STATS_EN
  ,
  output logic [31:0] stat_full_cycles,
  output logic [31:0] stat_conflict_cycles
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W + 1)'(1);

  typedef enum logic {RUN, FENCE} state_t;

  state_t state, state_next;
  logic   fence_done_q, fence_done_next;

  logic [DM_ADDRESS-1:0] addr_q   [DEPTH];
  logic [DATA_W-1:0]     data_q   [DEPTH];
  logic [2:0]            funct3_q [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             push, pop, addr_hit;

  assign bus.empty    = (count == '0);
  assign bus.st_ready = (count != FULL_COUNT) && (state != FENCE);
  assign push         = bus.st_valid && bus.st_ready;

  // Only slots inside the [head, head+count) window are live; everything else is ignored.
  always_comb begin
    // NOTE: a combinational result is given its default before the loop so no latch is inferred.
    addr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(PTR_W'(i) - head)} < count) && (addr_q[i] == bus.ld_addr))
        addr_hit = 1'b1;
    end
  end

  assign bus.ld_conflict = bus.ld_valid && addr_hit;
  // A conflicting load is stalled anyway, so the buffer takes the port and cannot deadlock.
  assign pop = !bus.empty && (!bus.ld_valid || bus.ld_conflict);

  assign bus.mem_we     = pop;
  assign bus.mem_addr   = addr_q[head];
  assign bus.mem_wd     = data_q[head];
  assign bus.mem_funct3 = funct3_q[head];
  assign bus.fence_done = fence_done_q;

  always_comb begin
    unique case (funct3_q[head])
      3'b000:  bus.mem_be = 4'b0001;
      3'b001:  bus.mem_be = 4'b0011;
      3'b010:  bus.mem_be = 4'b1111;
      default: bus.mem_be = 4'b0000;
    endcase
  end

  // NOTE: the entry array has no reset; liveness comes from head/count, which do reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail]   <= bus.st_addr;
      data_q[tail]   <= bus.st_data;
      funct3_q[tail] <= bus.st_funct3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      fence_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      fence_done_q <= fence_done_next;
    end
  end

  // Fence completes on the edge that leaves the buffer empty, including the final drain.
  always_comb begin
    state_next      = state;
    fence_done_next = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.fence_req) state_next = FENCE;
      end
      FENCE: begin
        if ((count == '0) || ((count == ONE_COUNT) && pop)) begin
          state_next      = RUN;
          fence_done_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

`ifdef STORE_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_full_cycles     <= '0;
      stat_conflict_cycles <= '0;
    end else begin
      if (bus.st_valid && !bus.st_ready && (stat_full_cycles != '1))
        stat_full_cycles <= stat_full_cycles + 32'd1;
      if (bus.ld_conflict && (stat_conflict_cycles != '1))
        stat_conflict_cycles <= stat_conflict_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order, full/refuse, load hazards, fence and async reset.
// Stat counter checks are compiled in when STORE_BUFFER_STATS_EN is defined.
module tb_store_buffer;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  store_buffer_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

`ifdef STORE_BUFFER_STATS_EN
  logic [31:0] stat_full_cycles;
  logic [31:0] stat_conflict_cycles;
`endif

  store_buffer #(.DEPTH(4), .DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk (clk),
    .rst_n (rst_n),
    .bus (bus)
`ifdef STORE_BUFFER_STATS_EN
    ,
    .stat_full_cycles (stat_full_cycles),
    .stat_conflict_cycles (stat_conflict_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1-2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_store(input logic v, input logic [8:0] a, input logic [31:0] d,
                           input logic [2:0] f3);
    bus.st_valid  = v;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_funct3 = f3;
  endtask

  initial begin
    rst_n         = 1'b0;
    set_store(1'b0, 9'h0, 32'h0, 3'b000);
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = 9'h0;
    bus.fence_req = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_empty", bus.empty, 1);
    check("rst_st_ready", bus.st_ready, 1);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_ld_conflict", bus.ld_conflict, 0);
    check("rst_fence_done", bus.fence_done, 0);

    // Single sw drains the cycle after it is accepted
    set_store(1'b1, 9'h010, 32'hDEADBEEF, 3'b010);
    tick();
    bus.st_valid = 1'b0;
    settle();
    check("sw_mem_we", bus.mem_we, 1);
    check("sw_mem_addr", bus.mem_addr, 9'h010);
    check("sw_mem_wd", bus.mem_wd, 32'hDEADBEEF);
    check("sw_mem_be", bus.mem_be, 4'b1111);
    tick();
    check("sw_empty_after", bus.empty, 1);
    check("sw_we_after", bus.mem_we, 0);

    // Load owns the port: fill to full, refuse a 5th, then drain in order
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 9'h020;
    for (int i = 1; i <= 4; i++) begin
      set_store(1'b1, 9'(i), 32'h100 + 32'(i), 3'b010);
      settle();
      check("fill_st_ready", bus.st_ready, 1);
      check("fill_mem_we", bus.mem_we, 0);
      tick();
    end
    set_store(1'b1, 9'h005, 32'h105, 3'b010);
    settle();
    check("full_st_ready", bus.st_ready, 0);
    check("full_mem_we", bus.mem_we, 0);
    tick();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("drain_mem_we", bus.mem_we, 1);
      check("drain_mem_addr", bus.mem_addr, 9'(i));
      check("drain_mem_wd", bus.mem_wd, 32'h100 + 32'(i));
      tick();
    end
    check("drain_empty", bus.empty, 1);
    check("drain_no_5th", bus.mem_we, 0);

    // Load hazard: same-cycle incoming store not compared; buffered sb is
    set_store(1'b1, 9'h005, 32'h000000AB, 3'b000);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 9'h005;
    settle();
    check("incoming_no_conflict", bus.ld_conflict, 0);
    tick();
    bus.st_valid = 1'b0;
    bus.ld_addr  = 9'h006;
    settle();
    check("miss_ld_conflict", bus.ld_conflict, 0);
    check("miss_mem_we", bus.mem_we, 0);
    bus.ld_addr = 9'h005;
    settle();
    check("hit_ld_conflict", bus.ld_conflict, 1);
    check("hit_mem_we", bus.mem_we, 1);
    check("hit_mem_be", bus.mem_be, 4'b0001);
    check("hit_mem_funct3", bus.mem_funct3, 3'b000);
    tick();
    check("hit_conflict_fall", bus.ld_conflict, 0);
    check("hit_empty", bus.empty, 1);
    bus.ld_valid = 1'b0;

    // Simultaneous push and pop
    set_store(1'b1, 9'h0A0, 32'h11111111, 3'b010);
    tick();
    set_store(1'b1, 9'h0A1, 32'h22222222, 3'b001);
    settle();
    check("pp_first_addr", bus.mem_addr, 9'h0A0);
    tick();
    bus.st_valid = 1'b0;
    settle();
    check("pp_not_empty", bus.empty, 0);
    check("pp_second_addr", bus.mem_addr, 9'h0A1);
    check("pp_second_be", bus.mem_be, 4'b0011);
    tick();
    check("pp_empty", bus.empty, 1);

    // Invalid funct3 still drains with no byte enables
    set_store(1'b1, 9'h00A, 32'h55555555, 3'b011);
    tick();
    bus.st_valid = 1'b0;
    settle();
    check("bad_f3_we", bus.mem_we, 1);
    check("bad_f3_be", bus.mem_be, 4'b0000);
    check("bad_f3_funct3", bus.mem_funct3, 3'b011);
    tick();

    // Fence with two buffered stores held back by a load
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 9'h030;
    set_store(1'b1, 9'h007, 32'h00001234, 3'b001);
    tick();
    set_store(1'b1, 9'h008, 32'hCAFEF00D, 3'b010);
    tick();
    bus.st_valid  = 1'b0;
    bus.fence_req = 1'b1;
    tick();
    check("fence_st_ready", bus.st_ready, 0);
    check("fence_done_early", bus.fence_done, 0);
    bus.ld_valid = 1'b0;
    settle();
    check("fence_drain1_addr", bus.mem_addr, 9'h007);
    check("fence_drain1_be", bus.mem_be, 4'b0011);
    tick();
    check("fence_done_mid", bus.fence_done, 0);
    check("fence_drain2_addr", bus.mem_addr, 9'h008);
    tick();
    check("fence_done_pulse", bus.fence_done, 1);
    check("fence_empty", bus.empty, 1);
    bus.fence_req = 1'b0;
    tick();
    check("fence_done_drop", bus.fence_done, 0);
    check("fence_ready_back", bus.st_ready, 1);

    // Fence on an empty buffer: one FENCE cycle, then the pulse
    bus.fence_req = 1'b1;
    tick();
    check("efence_st_ready", bus.st_ready, 0);
    check("efence_done_0", bus.fence_done, 0);
    tick();
    check("efence_done_1", bus.fence_done, 1);
    bus.fence_req = 1'b0;
    tick();
    check("efence_done_drop", bus.fence_done, 0);

    // Async reset mid-drain
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 9'h011 + 9'(i), 32'hA0 + 32'(i), 3'b010);
      tick();
    end
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    settle();
    check("rd_first_addr", bus.mem_addr, 9'h011);
    tick();
    check("rd_mid_we", bus.mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rd_async_we", bus.mem_we, 0);
    check("rd_async_empty", bus.empty, 1);
    check("rd_async_ready", bus.st_ready, 1);
    tick();
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rd_no_write", bus.mem_we, 0);
      tick();
    end

`ifdef STORE_BUFFER_STATS_EN
    // 5 refused store cycles, then 3 conflict cycles
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 9'h030;
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 9'h040 + 9'(i), 32'(i), 3'b010);
      tick();
    end
    set_store(1'b1, 9'h050, 32'h0, 3'b010);
    for (int i = 0; i < 5; i++) tick();
    bus.st_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_addr = 9'h040 + 9'(i);
      tick();
    end
    bus.ld_valid = 1'b0;
    settle();
    check("stat_full_cycles", stat_full_cycles, 32'd5);
    check("stat_conflict_cycles", stat_conflict_cycles, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
